// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, GF(2^8) doubling, Rcon, FSM states and key-size mapping.
package aes_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEXP,
        S_READY,
        S_ROUND,
        S_DONE
    } aes_state_t;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Entry b sits at bits 2047-8b; that offset is {~b, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Returns 0 for an illegal key size so the engine can refuse to elaborate.
    function automatic int key_words(input int key_bits);
        case (key_bits)
            128:     return 4;
            192:     return 6;
            256:     return 8;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One full AES round as pure logic; `last` drops MixColumns for the final round.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] blk,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] result
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        for (int b = 0; b < 16; b++) begin
            sb[b] = sbox(blk[127-8*b -: 8]);
        end
        // Byte index is 4*column + row; row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = gmul2(sr[4*c+0]) ^ gmul2(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c+0] ^ gmul2(sr[4*c+1]) ^ gmul2(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ gmul2(sr[4*c+2]) ^ gmul2(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = gmul2(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul2(sr[4*c+3]);
        end
        for (int b = 0; b < 16; b++) begin
            result[127-8*b -: 8] = (last ? sr[b] : mc[b]) ^ round_key[127-8*b -: 8];
        end
    end

endmodule

// File: rtl/aes_iter_engine.sv
// Iterative AES-128/192/256 encryptor: one-time key expansion, then one round per clock.
// Define AES_KEYCACHE_EN to skip re-expansion when the same key is loaded again while READY.
//
// state   | meaning
// S_IDLE  | no valid schedule, only a key is accepted
// S_KEXP  | expanding one schedule word per clock
// S_READY | schedule valid, waiting for a block (or a new key)
// S_ROUND | applying round rnd to the state register
// S_DONE  | ciphertext presented until downstream takes it
module aes_iter_engine
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] anahtar,
    input  logic         anahtar_gecerli,
    output logic         anahtar_hazir,
    input  logic [127:0] blok,
    input  logic         g_gecerli,
    output logic         hazir,
    output logic [127:0] sifre,
    output logic         c_gecerli,
    input  logic         c_hazir
);

    localparam int NK = key_words(KEY_BITS);
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [5:0] NK6    = 6'(NK);
    localparam logic [5:0] LAST_W = 6'(NW - 1);
    localparam logic [2:0] NKM1   = 3'(NK - 1);
    localparam logic [3:0] NR4    = 4'(NR);

    if (NK == 0) begin : g_bad_key_bits
        $error("aes_iter_engine: KEY_BITS must be 128, 192 or 256");
    end

    if (KEY_BITS < 256) begin : g_unused_key
        logic unused_key_bits;
        assign unused_key_bits = ^anahtar[255-KEY_BITS:0];
    end

    aes_state_t state, state_nxt;

    logic [KEY_BITS-1:0] key_used;
    logic [31:0]  w [NW];
    logic [5:0]   kidx;
    logic [2:0]   kmod;
    logic [3:0]   rc_idx;
    logic [3:0]   rnd;
    logic [127:0] st;
    logic [127:0] rk0, rk_sel, round_out;
    logic [31:0]  w_prev, w_back, w_tmp, w_new;
    logic         key_acc, key_hit, key_load, blk_acc;

    assign key_used = anahtar[255 -: KEY_BITS];
    assign key_acc  = anahtar_gecerli & anahtar_hazir;
    assign blk_acc  = g_gecerli & hazir;
    assign key_load = key_acc & ~key_hit;

`ifdef AES_KEYCACHE_EN
    logic [KEY_BITS-1:0] key_cache;
    logic                cache_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= 1'b0;
        end else if (key_acc) begin
            key_cache   <= key_used;
            cache_valid <= 1'b1;
        end
    end

    assign key_hit = (state == S_READY) && cache_valid && (key_cache == key_used);
`else
    assign key_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        anahtar_hazir = 1'b0;
        hazir         = 1'b0;
        c_gecerli     = 1'b0;
        case (state)
            S_IDLE: begin
                anahtar_hazir = 1'b1;
                if (anahtar_gecerli) state_nxt = S_KEXP;
            end
            S_KEXP: begin
                if (kidx == LAST_W) state_nxt = S_READY;
            end
            S_READY: begin
                hazir         = 1'b1;
                anahtar_hazir = ~g_gecerli;
                if (g_gecerli)            state_nxt = S_ROUND;
                else if (anahtar_gecerli) state_nxt = key_hit ? S_READY : S_KEXP;
            end
            S_ROUND: begin
                if (rnd == NR4) state_nxt = S_DONE;
            end
            S_DONE: begin
                c_gecerli = 1'b1;
                if (c_hazir) state_nxt = S_READY;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_prev = w[kidx - 6'd1];
        w_back = w[kidx - NK6];
        w_tmp  = w_prev;
        if (kmod == 3'd0)
            w_tmp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {RCON[rc_idx], 24'h0};
        else if (NK == 8 && kmod == 3'd4)
            w_tmp = sub_word(w_prev);
        w_new = w_back ^ w_tmp;
    end

    // Schedule storage carries no reset; the FSM state says whether it is valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (key_load) begin
                for (int k = 0; k < NK; k++) w[k] <= key_used[KEY_BITS-1-32*k -: 32];
            end else if (state == S_KEXP) begin
                w[kidx] <= w_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kidx   <= '0;
            kmod   <= '0;
            rc_idx <= '0;
        end else if (key_load) begin
            kidx   <= NK6;
            kmod   <= '0;
            rc_idx <= '0;
        end else if (state == S_KEXP) begin
            kidx <= kidx + 6'd1;
            if (kmod == NKM1) begin
                kmod   <= '0;
                rc_idx <= rc_idx + 4'd1;
            end else begin
                kmod <= kmod + 3'd1;
            end
        end
    end

    assign rk0    = {w[0], w[1], w[2], w[3]};
    assign rk_sel = {w[{rnd, 2'b00}], w[{rnd, 2'b01}], w[{rnd, 2'b10}], w[{rnd, 2'b11}]};

    aes_round_comb u_round (
        .blk       (st),
        .round_key (rk_sel),
        .last      (rnd == NR4),
        .result    (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= '0;
            rnd   <= '0;
            sifre <= '0;
        end else if (blk_acc) begin
            st  <= blok ^ rk0;
            rnd <= 4'd1;
        end else if (state == S_ROUND) begin
            st  <= round_out;
            rnd <= rnd + 4'd1;
            if (rnd == NR4) sifre <= round_out;
        end
    end

endmodule

// File: tb/tb_aes_iter_engine.sv
// Scoreboard bench for aes_iter_engine using FIPS-197 vectors for all three key sizes.
module tb_aes_iter_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [255:0] anahtar;
    logic         anahtar_gecerli, anahtar_hazir;
    logic [127:0] blok;
    logic         g_gecerli, hazir;
    logic [127:0] sifre;
    logic         c_gecerli, c_hazir;

    logic [255:0] kx;
    logic         kx_v, bx_v;
    logic [127:0] bx, s192, s256;
    logic         kh192, h192, cv192, kh256, h256, cv256;

    aes_iter_engine #(.KEY_BITS(128)) dut (
        .clk(clk), .rst(rst), .anahtar(anahtar), .anahtar_gecerli(anahtar_gecerli),
        .anahtar_hazir(anahtar_hazir), .blok(blok), .g_gecerli(g_gecerli), .hazir(hazir),
        .sifre(sifre), .c_gecerli(c_gecerli), .c_hazir(c_hazir)
    );

    aes_iter_engine #(.KEY_BITS(192)) dut192 (
        .clk(clk), .rst(rst), .anahtar(kx), .anahtar_gecerli(kx_v),
        .anahtar_hazir(kh192), .blok(bx), .g_gecerli(bx_v), .hazir(h192),
        .sifre(s192), .c_gecerli(cv192), .c_hazir(1'b1)
    );

    aes_iter_engine #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst(rst), .anahtar(kx), .anahtar_gecerli(kx_v),
        .anahtar_hazir(kh256), .blok(bx), .g_gecerli(bx_v), .hazir(h256),
        .sifre(s256), .c_gecerli(cv256), .c_hazir(1'b1)
    );

    localparam logic [255:0] KEY_A = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_B = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_Z = 256'h0;
    localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

`ifdef AES_KEYCACHE_EN
    localparam int RELOAD_LOW = 0;
`else
    localparam int RELOAD_LOW = 40;
`endif

    int passed = 0;
    int total  = 0;

    logic [127:0] q128[$];
    logic [127:0] q192[$];
    logic [127:0] q256[$];
    logic [127:0] exp_m;

    task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Scoreboard: compare whenever a ciphertext handshake is about to complete.
    always @(negedge clk) begin
        if (!rst && c_gecerli && c_hazir) begin
            if (q128.size() == 0) chk(1'b0, "unexpected_out128", sifre, '0);
            else begin
                exp_m = q128.pop_front();
                chk(sifre == exp_m, "cipher128", sifre, exp_m);
            end
        end
        if (!rst && cv192) begin
            if (q192.size() == 0) chk(1'b0, "unexpected_out192", s192, '0);
            else begin
                exp_m = q192.pop_front();
                chk(s192 == exp_m, "cipher192", s192, exp_m);
            end
        end
        if (!rst && cv256) begin
            if (q256.size() == 0) chk(1'b0, "unexpected_out256", s256, '0);
            else begin
                exp_m = q256.pop_front();
                chk(s256 == exp_m, "cipher256", s256, exp_m);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [255:0] k, input int exp_low, input string nm);
        int n = 0;
        anahtar = k;
        anahtar_gecerli = 1'b1;
        while (!anahtar_hazir && n < 200) begin cyc(); n++; end
        chk(anahtar_hazir, {nm, "_key_ready"}, 128'(anahtar_hazir), 128'd1);
        cyc();
        anahtar_gecerli = 1'b0;
        anahtar = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        n = 0;
        while (!anahtar_hazir && n < 200) begin cyc(); n++; end
        chk(n == exp_low, {nm, "_kexp_cycles"}, 128'(n), 128'(exp_low));
    endtask

    task automatic send_block(input logic [127:0] b, input logic [127:0] exp, input bit push, input string nm);
        int n = 0;
        blok = b;
        g_gecerli = 1'b1;
        while (!hazir && n < 200) begin cyc(); n++; end
        chk(hazir, {nm, "_blk_ready"}, 128'(hazir), 128'd1);
        cyc();
        g_gecerli = 1'b0;
        blok = {$urandom, $urandom, $urandom, $urandom};
        if (push) q128.push_back(exp);
    endtask

    task automatic wait_out(input int lat, input string nm);
        int n = 0;
        while (!c_gecerli && n < 100) begin cyc(); n++; end
        chk(n == lat, {nm, "_latency"}, 128'(n), 128'(lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n1, n2;
        bit ok;
        logic [127:0] cap;

        rst = 1'b1;
        anahtar = '0; anahtar_gecerli = 1'b0; blok = '0; g_gecerli = 1'b0; c_hazir = 1'b1;
        kx = '0; kx_v = 1'b0; bx = '0; bx_v = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;

        chk(anahtar_hazir == 1'b1, "rst_anahtar_hazir", 128'(anahtar_hazir), 128'd1);
        chk(hazir == 1'b0, "rst_hazir", 128'(hazir), 128'd0);
        chk(c_gecerli == 1'b0, "rst_c_gecerli", 128'(c_gecerli), 128'd0);
        chk(sifre == '0, "rst_sifre", sifre, '0);

        // AES-192 and AES-256 side by side on a shared key/block.
        kx = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        kx_v = 1'b1;
        cyc();
        kx_v = 1'b0;
        n = 0; n1 = -1; n2 = -1;
        while ((n1 < 0 || n2 < 0) && n < 100) begin
            cyc(); n++;
            if (n1 < 0 && kh192) n1 = n;
            if (n2 < 0 && kh256) n2 = n;
        end
        chk(n1 == 46, "kexp192_cycles", 128'(n1), 128'd46);
        chk(n2 == 52, "kexp256_cycles", 128'(n2), 128'd52);
        bx = PT_B;
        bx_v = 1'b1;
        chk(h192 && h256, "wide_blk_ready", {h192, h256}, 2'b11);
        cyc();
        bx_v = 1'b0;
        q192.push_back(CT_192);
        q256.push_back(CT_256);
        n = 0; n1 = -1; n2 = -1;
        while ((n1 < 0 || n2 < 0) && n < 100) begin
            cyc(); n++;
            if (n1 < 0 && cv192) n1 = n;
            if (n2 < 0 && cv256) n2 = n;
        end
        chk(n1 == 12, "lat192", 128'(n1), 128'd12);
        chk(n2 == 14, "lat256", 128'(n2), 128'd14);

        // AES-128 basic vector.
        load_key(KEY_A, 40, "keyA");
        send_block(PT_A, CT_A, 1'b1, "blkA");
        wait_out(10, "blkA");
        cyc();

        // Backpressure in DONE.
        c_hazir = 1'b0;
        send_block(PT_A, CT_A, 1'b1, "bp");
        wait_out(10, "bp");
        cap = sifre;
        ok = 1'b1;
        repeat (20) begin
            cyc();
            if (sifre != cap || !c_gecerli || hazir) ok = 1'b0;
        end
        chk(ok, "bp_hold", sifre, cap);
        c_hazir = 1'b1;
        cyc();
        chk(hazir == 1'b1, "bp_release_ready", 128'(hazir), 128'd1);
        chk(c_gecerli == 1'b0, "bp_release_cvalid", 128'(c_gecerli), 128'd0);
        chk(sifre == cap, "bp_sifre_kept", sifre, cap);
        send_block(PT_A, CT_A, 1'b1, "bp2");
        wait_out(10, "bp2");
        cyc();

        // Key and block together in READY: block wins with the old key.
        anahtar = KEY_B; anahtar_gecerli = 1'b1;
        blok = PT_A; g_gecerli = 1'b1;
        #1;
        chk(anahtar_hazir == 1'b0, "simul_key_blocked", 128'(anahtar_hazir), 128'd0);
        cyc();
        g_gecerli = 1'b0;
        q128.push_back(CT_A);
        wait_out(10, "simul_old");
        load_key(KEY_B, 40, "keyB");
        send_block(PT_B, CT_B, 1'b1, "blkB");
        wait_out(10, "blkB");
        cyc();

        // Reset while the round counter is at 5.
        send_block(PT_B, '0, 1'b0, "abort");
        repeat (4) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk(c_gecerli == 1'b0, "abort_c_gecerli", 128'(c_gecerli), 128'd0);
        chk(sifre == '0, "abort_sifre", sifre, '0);
        chk(hazir == 1'b0, "abort_hazir", 128'(hazir), 128'd0);
        chk(anahtar_hazir == 1'b1, "abort_idle", 128'(anahtar_hazir), 128'd1);
        blok = PT_A; g_gecerli = 1'b1;
        ok = 1'b1;
        repeat (6) begin
            if (hazir || c_gecerli) ok = 1'b0;
            cyc();
        end
        g_gecerli = 1'b0;
        chk(ok, "no_block_without_key", 128'(hazir), 128'd0);

        load_key(KEY_Z, 40, "keyZ");
        send_block('0, CT_Z, 1'b1, "blkZ");
        wait_out(10, "blkZ");
        cyc();

        // Same key again, then a different one.
        load_key(KEY_Z, RELOAD_LOW, "reloadZ");
        send_block('0, CT_Z, 1'b1, "blkZ2");
        wait_out(10, "blkZ2");
        cyc();
        load_key(KEY_A, 40, "keyA2");
        send_block(PT_A, CT_A, 1'b1, "blkA2");
        wait_out(10, "blkA2");
        repeat (3) cyc();

        chk(q128.size() == 0 && q192.size() == 0 && q256.size() == 0, "queues_drained",
            128'(q128.size() + q192.size() + q256.size()), 128'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
